// File: rtl/serial_frame_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_tx_pkg
// Purpose  : Shared state encoding and line constants for the serial frame
//            transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package serial_frame_tx_pkg;

  // Frame phases, in line order.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Level the serial line rests at between frames (also the stop bit level).
  localparam logic C_LINE_IDLE = 1'b1;

  // Level driven for the start bit.
  localparam logic C_LINE_START = 1'b0;

endpackage : serial_frame_tx_pkg
`default_nettype wire

// File: rtl/serial_frame_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_tx_bit_timer
// Purpose  : Modulo-BIT_CYCLES counter. tick_o marks the last clock of each
//            serial bit; clear_i holds the count at zero.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_tx_bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int              CW     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0]   C_LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: zero on clear, wrap after the last cycle of a bit.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_q == C_LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = (count_q == C_LAST);

endmodule : serial_frame_tx_bit_timer
`default_nettype wire

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_tx
// Purpose  : Parallel-to-serial frame transmitter. Sends start bit (0), data
//            LSB first, even parity bit, stop bit (1); each bit is held for
//            BIT_CYCLES clocks. Outputs decode from registered state only.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  load_i,
  output logic                  ready_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int            IW         = $clog2(DATA_WIDTH + 1);
  localparam logic [IW-1:0] C_LAST_IDX = IW'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  bit_tick;
  logic                  timer_clear;

  // The timer rests at zero while idle, so the start bit always begins on a
  // fresh count the cycle after a load is accepted.
  assign timer_clear = (state_q == ST_IDLE);

  serial_frame_tx_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (timer_clear),
    .tick_o  (bit_tick)
  );

  // Next-state logic: frame sequencing, word capture and data shifting.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    idx_d    = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          shift_d  = data_i;
          parity_d = ^data_i;
          idx_d    = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IW'(1);
          if (idx_q == C_LAST_IDX) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state; no path from load_i or data_i.
  always_comb begin
    tx_o    = C_LINE_IDLE;
    ready_o = 1'b0;
    busy_o  = 1'b1;
    done_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
      end
      ST_START:  tx_o = C_LINE_START;
      ST_DATA:   tx_o = shift_q[0];
      ST_PARITY: tx_o = parity_q;
      ST_STOP: begin
        tx_o   = C_LINE_IDLE;
        done_o = bit_tick;
      end
      default: begin
        tx_o    = C_LINE_IDLE;
        ready_o = 1'b1;
        busy_o  = 1'b0;
      end
    endcase
  end

  // State, shift, parity and bit-index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      parity_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      idx_q    <= idx_d;
    end
  end

endmodule : serial_frame_tx
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_tx
// Purpose  : Self-checking bench for serial_frame_tx. A reference model keeps
//            a queue of expected per-cycle line values for the frame in
//            flight; every cycle the DUT outputs are compared against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_frame_tx;

  localparam int DW        = 8;
  localparam int BC        = 4;
  localparam int FRAME_CYC = (DW + 3) * BC;

  logic          clk;
  logic          rst;
  logic [DW-1:0] data_i;
  logic          load_i;
  logic          ready_o;
  logic          tx_o;
  logic          busy_o;
  logic          done_o;

  int n_checks;
  int n_pass;

  serial_frame_tx #(
    .DATA_WIDTH (DW),
    .BIT_CYCLES (BC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .load_i  (load_i),
    .ready_o (ready_o),
    .tx_o    (tx_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison: counts every call, reports any difference.
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each entry is one expected cycle on the line: {tx, done}.
  logic [1:0] exp_q[$];

  // Builds the 44-cycle line picture of one frame from the word.
  task automatic push_frame(input logic [DW-1:0] w);
    logic b;
    for (int s = 0; s < DW + 3; s++) begin
      if (s == 0)            b = 1'b0;
      else if (s <= DW)      b = w[s-1];
      else if (s == DW + 1)  b = ^w;
      else                   b = 1'b1;
      for (int c = 0; c < BC; c++) begin
        exp_q.push_back({b, (s == DW + 2) && (c == BC - 1)});
      end
    end
  endtask

  // Model update at each edge: a cycle of the frame elapses, or an idle
  // cycle with load starts a new frame.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
      end else if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end else if (load_i) begin
        push_frame(data_i);
      end
    end
  end

  // Per-cycle output comparison, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check_eq("tx_idle",  tx_o,    1);
        check_eq("ready",    ready_o, 1);
        check_eq("busy",     busy_o,  0);
        check_eq("done",     done_o,  0);
      end else begin
        check_eq("tx_frame", tx_o,    exp_q[0][1]);
        check_eq("ready",    ready_o, 0);
        check_eq("busy",     busy_o,  1);
        check_eq("done",     done_o,  exp_q[0][0]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!ready_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_wait", ready_o, 1);
  endtask

  // One-cycle load pulse, then measure the busy span.
  task automatic send(input logic [DW-1:0] w);
    int len;
    @(negedge clk);
    data_i = w;
    load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    len = 0;
    while (busy_o && len < 200) begin
      len++;
      @(negedge clk);
    end
    check_eq("frame_len", len, FRAME_CYC);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    load_i   = 1'b0;
    data_i   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    repeat (20) @(negedge clk);

    // Directed frames, including both parity values.
    send(8'hA5);
    send(8'h01);
    send(8'hFF);
    repeat (3) @(negedge clk);

    // Back-to-back with load held high, data changing mid-frame,
    // then stray load pulses during the second frame.
    @(negedge clk);
    data_i = 8'h3C;
    load_i = 1'b1;
    repeat (10) @(negedge clk);
    data_i = 8'hC3;
    repeat (FRAME_CYC - 10 + 1 + 5) @(negedge clk);
    load_i = 1'b0;
    check_eq("b2b_busy", busy_o, 1);
    repeat (10) @(negedge clk);
    load_i = 1'b1;
    data_i = 8'h77;
    @(negedge clk);
    load_i = 1'b0;
    wait_idle(200);
    repeat (4) @(negedge clk);

    // Randomised load and data activity; data changes every cycle.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      data_i = DW'($urandom);
      load_i = ($urandom_range(0, 7) == 0);
    end
    load_i = 1'b0;
    wait_idle(200);

    // Asynchronous reset in cycle 17 of a frame.
    @(negedge clk);
    data_i = 8'h5A;
    load_i = 1'b1;
    @(posedge clk);
    #1;
    load_i = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst_tx",   tx_o,    1);
    check_eq("rst_busy", busy_o,  0);
    check_eq("rst_rdy",  ready_o, 1);
    check_eq("rst_done", done_o,  0);
    repeat (2) @(negedge clk);
    // Release with load already high: accepted at the next edge.
    data_i = 8'h96;
    load_i = 1'b1;
    rst    = 1'b0;
    @(negedge clk);
    load_i = 1'b0;
    check_eq("post_rst_busy", busy_o, 1);
    wait_idle(200);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule : tb_serial_frame_tx
`default_nettype wire

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter that turns a parallel word into a framed, bit-serial line: start bit, data LSB-first, even parity, stop bit. It is the sending end of the lab's serial-input FSM interface. It produces the single-wire bit stream, one bit per fixed number of clocks, that a downstream receiver/detector samples. It sits between a parallel producer (switches, counter, test stimulus) and the serial line.

## Interface
- DATA_WIDTH, 8, data bits per frame (≥1)
- BIT_CYCLES, 4, clock cycles each serial bit is held (≥1)

- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- data_in  input  DATA_WIDTH  word to send, sampled only on an accepted load
- load  input  1  request to send data_in
- ready  output  1  high when a load will be accepted (IDLE only)
- tx  output  1  serial line, idles high
- busy  output  1  high while a frame is on the line
- done  output  1  one-cycle pulse during the last cycle of the stop bit

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, ready=1, busy=0.
  - load=1 at a rising edge is an accepted load: capture data_in into the shift register, compute even parity (XOR of all bits), clear bit timer and bit index, go to START.
- START: tx=0 for BIT_CYCLES cycles, then go to DATA.
- DATA:
  - tx = shift register bit 0.
  - Every BIT_CYCLES cycles, shift right and increment the bit index.
  - After DATA_WIDTH bits, go to PARITY.
- PARITY: tx = parity bit (1 if the captured word has an odd count of ones) for BIT_CYCLES cycles, then go to STOP.
- STOP:
  - tx=1 for BIT_CYCLES cycles.
  - done=1 in the final cycle.
  - Then go to IDLE.
- Any state other than IDLE: ready=0, busy=1.
- load is ignored outside IDLE; no queuing. data_in changes after capture have no effect.
- Bit timer counts 0..BIT_CYCLES-1 and wraps. Its width is clog2(BIT_CYCLES), minimum 1. The bit index width is clog2(DATA_WIDTH+1).

## Timing
- Reset values: tx=1, ready=1, busy=0, done=0; state IDLE; shift register, parity, timer and index all 0.
- Reset asserted mid-frame forces tx=1 and IDLE immediately (asynchronously). No done pulse; the partial frame is abandoned.
- All outputs are registered, or decoded from registered state only; no combinational path from load or data_in to any output.
- Latency and frame length:
  - Load accepted at edge k: tx=0 from edge k through edge k+BIT_CYCLES.
  - Frame occupies exactly (DATA_WIDTH+3)·BIT_CYCLES cycles.
  - done is high in the cycle before the return to IDLE.
  - ready rises at edge k+(DATA_WIDTH+3)·BIT_CYCLES.
- Back-to-back frames: load held high continuously is accepted on the first edge with ready=1. The next start bit begins with no idle gap beyond that edge.
- BIT_CYCLES=1: every state holds exactly one cycle; done coincides with the single stop cycle.
- load asserted in the same cycle that rst deasserts is accepted at the next rising edge.

## Structure
- Shared package/header holds:
  - the state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3-bit)
  - the constant for line idle level (1)
- One sub-module is natural: bit_timer.
  - Parameterised modulo-BIT_CYCLES counter with clear input and a tick output (high when count = BIT_CYCLES-1).
  - Same clk/rst convention.
- Top level holds the FSM, shift register, parity register and bit index.

## Test plan
All scenarios use DATA_WIDTH=8, BIT_CYCLES=4.
- Reset then idle 20 cycles → tx=1, ready=1, busy=0, done=0 throughout.
- Load 0xA5 → tx sequence per 4-cycle slot: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. Frame is 44 cycles; done pulses once in cycle 44; ready returns at cycle 44 edge.
- Load 0x01, then 0xFF → parity slot 1 for 0x01, parity slot 0 for 0xFF.
- load held high continuously with data_in 0x3C then 0xC3 → two contiguous 44-cycle frames, no extra idle slot. load pulses during busy are ignored, with no third frame.
- Change data_in during DATA slots → transmitted bits still match the captured word.
- Assert rst at cycle 17 of a frame → tx=1 and busy=0 within the same cycle, no done pulse. A new load after release sends a full, correct frame.
